// File: rtl/dp_share_pkg.sv
// Shared types and defaults for the two-requester datapath arbiter.
package dp_share_pkg;

    localparam int DP_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DECIDE = 3'd2,
        EXEC   = 3'd3,
        RESP   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_DIV = 2'd1,
        OP_CLR = 2'd2
    } op_e;

    // Positive AR doubles BR, negative AR halves AR, zero clears.
    // Both flags high cannot happen on a sane datapath; MUL is the tie-break.
    function automatic op_e decode_op(input logic gt, input logic lt);
        if (gt) begin
            return OP_MUL;
        end else if (lt) begin
            return OP_DIV;
        end else begin
            return OP_CLR;
        end
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with a last-served pointer.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_reset_b,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_served,
    output logic       o_valid,
    output logic       o_idx
);

    logic r_ptr;

    // Remember who was served last; reset favours requester 0 on first contention.
    always_ff @(posedge i_clk or negedge i_reset_b) begin
        if (!i_reset_b) begin
            r_ptr <= 1'b1;
        end else if (i_update) begin
            r_ptr <= i_served;
        end
    end

    // Contention goes to whoever was not served last; otherwise the lone requester.
    always_comb begin
        o_valid = |i_req;
        if (i_req == 2'b11) begin
            o_idx = ~r_ptr;
        end else begin
            o_idx = i_req[1];
        end
    end

endmodule

// File: rtl/dp_share_arbiter.sv
// Shares one AR/BR/CR datapath between two requesters: arbitrate, sequence
// the datapath strobes, and return CR to the winner with a one-cycle ack.
module dp_share_arbiter
    import dp_share_pkg::*;
#(
    parameter int WIDTH = DP_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_reset_b,
    input  logic [1:0]       i_req,
    input  logic [WIDTH-1:0] i_data_ar_0,
    input  logic [WIDTH-1:0] i_data_br_0,
    input  logic [WIDTH-1:0] i_data_ar_1,
    input  logic [WIDTH-1:0] i_data_br_1,
    output logic [1:0]       o_ack,
    output logic [WIDTH-1:0] o_result,
    output logic             o_grant_id,
    output logic             o_busy,
    output logic [7:0]       o_op_count,
    output logic [WIDTH-1:0] o_data_ar,
    output logic [WIDTH-1:0] o_data_br,
    output logic             o_ld_ar_br,
    output logic             o_div_ar_x2_cr,
    output logic             o_mul_br_x2_cr,
    output logic             o_clr_cr,
    input  logic             i_ar_gt_0,
    input  logic             i_ar_lt_0,
    input  logic [WIDTH-1:0] i_cr
);

    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_op_ar;
    logic [WIDTH-1:0] r_op_br;
    logic [WIDTH-1:0] r_result;
    logic [1:0]       r_ack;
    logic             r_grant_id;
    logic [7:0]       r_op_count;

    logic             w_grant_valid;
    logic             w_grant_idx;
    logic             w_ptr_update;

    assign w_ptr_update = (r_state == RESP);

    rr_arb2 u_rr_arb2 (
        .i_clk     (i_clk),
        .i_reset_b (i_reset_b),
        .i_req     (i_req),
        .i_update  (w_ptr_update),
        .i_served  (r_grant_id),
        .o_valid   (w_grant_valid),
        .o_idx     (w_grant_idx)
    );

    // Main sequencer. Ack, result and count are loaded on the EXEC->RESP edge
    // (CR is valid there) so they are all visible during the RESP cycle.
    always_ff @(posedge i_clk or negedge i_reset_b) begin
        if (!i_reset_b) begin
            r_state    <= IDLE;
            r_op       <= OP_CLR;
            r_op_ar    <= '0;
            r_op_br    <= '0;
            r_result   <= '0;
            r_ack      <= 2'b00;
            r_grant_id <= 1'b0;
            r_op_count <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_op_ar    <= w_grant_idx ? i_data_ar_1 : i_data_ar_0;
                        r_op_br    <= w_grant_idx ? i_data_br_1 : i_data_br_0;
                        r_grant_id <= w_grant_idx;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    r_state <= DECIDE;
                end
                DECIDE: begin
                    r_op    <= decode_op(i_ar_gt_0, i_ar_lt_0);
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_result   <= i_cr;
                    r_ack      <= r_grant_id ? 2'b10 : 2'b01;
                    r_op_count <= r_op_count + 8'd1;
                    r_state    <= RESP;
                end
                RESP: begin
                    r_ack   <= 2'b00;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Strobes are pure decodes of the state register, so at most one is ever high.
    always_comb begin
        o_ld_ar_br     = (r_state == LOAD);
        o_mul_br_x2_cr = (r_state == EXEC) && (r_op == OP_MUL);
        o_div_ar_x2_cr = (r_state == EXEC) && (r_op == OP_DIV);
        o_clr_cr       = (r_state == EXEC) && (r_op == OP_CLR);
    end

    assign o_busy     = (r_state != IDLE);
    assign o_data_ar  = o_busy ? r_op_ar : '0;
    assign o_data_br  = o_busy ? r_op_br : '0;
    assign o_ack      = r_ack;
    assign o_result   = r_result;
    assign o_grant_id = r_grant_id;
    assign o_op_count = r_op_count;

endmodule

// File: tb/tb_dp_share_arbiter.sv
// Self-checking bench for dp_share_arbiter with a behavioural AR/BR/CR datapath.
module tb_dp_share_arbiter;

    logic        clk;
    logic        reset_b;
    logic [1:0]  req;
    logic [15:0] ar0, br0, ar1, br1;
    logic [1:0]  ack;
    logic [15:0] result;
    logic        grant_id, busy;
    logic [7:0]  op_count;
    logic [15:0] data_ar, data_br;
    logic        ld, div, mul, clr;
    logic        gt, lt;
    logic [15:0] cr;

    logic signed [15:0] dp_ar, dp_br, dp_cr;
    logic               force_both;

    int total = 0;
    int bad   = 0;
    int exp_count = 0;

    dp_share_arbiter dut (
        .i_clk          (clk),
        .i_reset_b      (reset_b),
        .i_req          (req),
        .i_data_ar_0    (ar0),
        .i_data_br_0    (br0),
        .i_data_ar_1    (ar1),
        .i_data_br_1    (br1),
        .o_ack          (ack),
        .o_result       (result),
        .o_grant_id     (grant_id),
        .o_busy         (busy),
        .o_op_count     (op_count),
        .o_data_ar      (data_ar),
        .o_data_br      (data_br),
        .o_ld_ar_br     (ld),
        .o_div_ar_x2_cr (div),
        .o_mul_br_x2_cr (mul),
        .o_clr_cr       (clr),
        .i_ar_gt_0      (gt),
        .i_ar_lt_0      (lt),
        .i_cr           (cr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Datapath model: acts on the negedge inside each strobe cycle.
    always @(negedge clk) begin
        if (ld) begin
            dp_ar <= data_ar;
            dp_br <= data_br;
        end
        if (div) dp_cr <= dp_ar / 16'sd2;
        if (mul) dp_cr <= dp_br <<< 1;
        if (clr) dp_cr <= 16'sd0;
    end

    assign gt = force_both ? 1'b1 : (dp_ar > 16'sd0);
    assign lt = force_both ? 1'b1 : (dp_ar < 16'sd0);
    assign cr = dp_cr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Continuous structural checks every cycle out of reset.
    always @(negedge clk) begin
        if (reset_b) begin
            chk("one_strobe_max", ($countones({ld, div, mul, clr}) > 1) ? 32'd1 : 32'd0, 32'd0);
            if (!busy) chk("idle_data_zero", {data_ar, data_br}, 32'd0);
        end
    end

    task automatic wait_ack(input int budget, output logic [1:0] a, output int cyc);
        a   = 2'b00;
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ack != 2'b00) begin
                a = ack;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_b = 1'b0;
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_result", result, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", op_count, 0);
        chk("rst_strobes", {ld, div, mul, clr}, 0);
        chk("rst_data", {data_ar, data_br}, 0);
        exp_count = 0;
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [15:0] ar0, br0, ar1, br1;
        logic        both;
        logic [1:0]  exp_ack;
        logic [15:0] exp_result;
        logic        exp_grant;
        logic [3:0]  exp_strb;   // {ld, mul, div, clr} seen during the op
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [1:0]  a;
        int          cyc;
        logic [3:0]  seen;
        logic [15:0] sav_ar, sav_br;
        int          nacks;
        logic        found;

        reset_b = 1'b1;
        req = 2'b00; ar0 = '0; br0 = '0; ar1 = '0; br1 = '0;
        force_both = 1'b0;
        dp_ar = '0; dp_br = '0; dp_cr = '0;

        // unused pair 0x0003/0x0100 would yield 0x0200 if muxed in by mistake
        vecs[0] = '{2'b01, 16'h0005, 16'h0007, 16'h0003, 16'h0100, 1'b0, 2'b01, 16'h000E, 1'b0, 4'b1100};
        vecs[1] = '{2'b10, 16'h0003, 16'h0100, 16'hFFFD, 16'h0009, 1'b0, 2'b10, 16'hFFFF, 1'b1, 4'b1010};
        vecs[2] = '{2'b01, 16'h0000, 16'd123,  16'h0003, 16'h0100, 1'b0, 2'b01, 16'h0000, 1'b0, 4'b1001};
        vecs[3] = '{2'b10, 16'h0003, 16'h0100, 16'h0001, 16'h4000, 1'b0, 2'b10, 16'h8000, 1'b1, 4'b1100};
        vecs[4] = '{2'b01, 16'hFFF8, 16'h0011, 16'h0003, 16'h0100, 1'b0, 2'b01, 16'hFFFC, 1'b0, 4'b1010};
        vecs[5] = '{2'b10, 16'h0003, 16'h0100, 16'hFFFD, 16'h0005, 1'b1, 2'b10, 16'h000A, 1'b1, 4'b1100};
        vecs[6] = '{2'b01, 16'h7FFF, 16'hFFFF, 16'h0003, 16'h0100, 1'b0, 2'b01, 16'hFFFE, 1'b0, 4'b1100};
        vecs[7] = '{2'b10, 16'h0003, 16'h0100, 16'h8000, 16'h0001, 1'b0, 2'b10, 16'hC000, 1'b1, 4'b1010};

        #2;
        do_reset();

        // ---- table-driven single-request operations ----
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req = vecs[i].req;
            ar0 = vecs[i].ar0; br0 = vecs[i].br0;
            ar1 = vecs[i].ar1; br1 = vecs[i].br1;
            force_both = vecs[i].both;
            sav_ar = vecs[i].exp_grant ? vecs[i].ar1 : vecs[i].ar0;
            sav_br = vecs[i].exp_grant ? vecs[i].br1 : vecs[i].br0;
            seen = 4'b0000;
            a = 2'b00;
            cyc = 0;
            while (cyc < 10) begin
                @(negedge clk);
                cyc++;
                seen = seen | {ld, mul, div, clr};
                if (cyc == 1) begin
                    chk($sformatf("v%0d_load_ar", i), data_ar, sav_ar);
                    ar0 = 16'h1234; br0 = 16'h5678; ar1 = 16'h9ABC; br1 = 16'hDEF0;
                end
                if (cyc == 3) chk($sformatf("v%0d_exec_ops", i), {data_ar, data_br}, {sav_ar, sav_br});
                if (ack != 2'b00) begin
                    a = ack;
                    break;
                end
            end
            exp_count++;
            chk($sformatf("v%0d_ack", i), a, vecs[i].exp_ack);
            chk($sformatf("v%0d_latency", i), cyc, 4);
            chk($sformatf("v%0d_result", i), result, vecs[i].exp_result);
            chk($sformatf("v%0d_grant", i), grant_id, vecs[i].exp_grant);
            chk($sformatf("v%0d_strobes", i), seen, vecs[i].exp_strb);
            chk($sformatf("v%0d_count", i), op_count, exp_count);
            req = 2'b00;
            force_both = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_ack_pulse", i), ack, 0);
            chk($sformatf("v%0d_result_held", i), result, vecs[i].exp_result);
            $display("vec %0d: ack=%b result=%h grant=%0d count=%0d", i, a, result, grant_id, op_count);
        end

        // ---- contention: req=11 held for 4 ops, alternating from requester 0 ----
        do_reset();
        ar0 = 16'h0005; br0 = 16'h0007; ar1 = 16'hFFFD; br1 = 16'h0009;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ack(8, a, cyc);
            chk($sformatf("rr%0d_ack", k), a, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr%0d_spacing", k), cyc, (k == 0) ? 4 : 5);
            chk($sformatf("rr%0d_result", k), result, (k % 2 == 0) ? 16'h000E : 16'hFFFF);
            $display("contention %0d: ack=%b after %0d cycles result=%h", k, a, cyc, result);
        end
        req = 2'b00;
        @(negedge clk);

        // ---- reset during EXEC, then re-arbitration from pointer=1 ----
        @(negedge clk);
        req = 2'b01;                         // serve requester 0 so pointer -> 0
        wait_ack(8, a, cyc);
        chk("pre_abort_ack", a, 2'b01);
        req = 2'b00;
        @(negedge clk);
        req = 2'b10;
        found = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mul | div | clr) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_reached_exec", found, 1);
        reset_b = 1'b0;
        #1;
        chk("abort_ack", ack, 0);
        chk("abort_busy", busy, 0);
        chk("abort_strobes", {ld, div, mul, clr}, 0);
        chk("abort_result", result, 0);
        chk("abort_count", op_count, 0);
        chk("abort_data", {data_ar, data_br}, 0);
        exp_count = 0;
        req = 2'b11;
        @(negedge clk);
        reset_b = 1'b1;
        wait_ack(8, a, cyc);
        chk("post_abort_ack", a, 2'b01);
        chk("post_abort_result", result, 16'h000E);
        chk("post_abort_count", op_count, 1);
        $display("abort: first ack after release=%b result=%h", a, result);
        req = 2'b00;
        @(negedge clk);

        // ---- early req drop: op still completes ----
        @(negedge clk);
        ar0 = 16'h0000; br0 = 16'h0005;
        req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        req = 2'b00;
        wait_ack(6, a, cyc);
        chk("drop_ack", a, 2'b01);
        chk("drop_result", result, 16'h0000);
        chk("drop_count", op_count, 2);
        $display("early drop: ack=%b result=%h count=%0d", a, result, op_count);
        @(negedge clk);

        // ---- 256 back-to-back ops wrap the counter ----
        do_reset();
        ar0 = 16'h0005; br0 = 16'h0007;
        req = 2'b01;
        nacks = 0;
        for (int c = 0; c < 1400; c++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                nacks++;
                if (nacks == 255) chk("wrap_count_255", op_count, 255);
                if (nacks == 256) break;
            end
        end
        chk("wrap_acks", nacks, 256);
        chk("wrap_count_0", op_count, 0);
        $display("wrap: acks=%0d count=%0d", nacks, op_count);
        req = 2'b00;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dp_share_arbiter.md
# dp_share_arbiter

Arbiter and sequencer that shares one AR/BR/CR datapath (load, AR/2, BR×2, clear) between two requesters. Each requester submits an operand pair. The block grants round-robin, drives the datapath control strobes in sequence and reads the AR sign flags. It returns the CR result to the winner with a one-cycle ack. It replaces the single-user control unit when two masters need the same datapath.

## Interface
- WIDTH, 16, operand/result width (signed two's complement)
- clk  in  1  clock; all state updates on posedge
- reset_b  in  1  asynchronous, active-low reset
- req  in  2  per-requester request level; bit i = requester i
- data_ar_0, data_br_0  in  WIDTH each  requester 0 operands
- data_ar_1, data_br_1  in  WIDTH each  requester 1 operands
- ack  out  2  one-cycle pulse to the served requester; result valid same cycle
- result  out  WIDTH  signed result; held until next ack
- grant_id  out  1  index of requester currently being served
- busy  out  1  high in every state except IDLE
- op_count  out  8  completed operations, wraps 255→0
- Data_AR, Data_BR  out  WIDTH each  operands to datapath
- Ld_AR_BR, Div_AR_x2_CR, Mul_BR_x2_CR, Clr_CR  out  1 each  datapath strobes
- AR_gt_0, AR_lt_0  in  1 each  datapath sign flags
- CR  in  WIDTH  datapath result register

## Operation
- States: IDLE, LOAD, DECIDE, EXEC, RESP.
  - IDLE: if any req bit set, pick the winner, capture its operands into internal op registers, latch grant_id, go to LOAD.
  - LOAD: Ld_AR_BR=1 → DECIDE.
  - DECIDE: sample flags, latch op code → EXEC.
  - EXEC: exactly one op strobe → RESP.
  - RESP: result←CR, ack[grant_id]=1, op_count+1 → IDLE.
- Op decode in DECIDE:
  - AR_gt_0 → MUL (Mul_BR_x2_CR).
  - else AR_lt_0 → DIV (Div_AR_x2_CR).
  - else → CLR (Clr_CR).
  - Both flags set is illegal and resolves to MUL.
- Round-robin: last-served pointer. If both requests are pending, grant the requester that was not served last. Pointer resets to 1, so requester 0 wins the first contention.
- Data_AR/Data_BR driven from the op registers, constant from LOAD through RESP; zero in IDLE.
- Strobes are Moore decodes of the state register; at most one strobe high per cycle; all zero in IDLE, DECIDE, RESP.
- Arithmetic is performed by the datapath; the block forwards CR unchanged.
  - BR×2 wraps to WIDTH bits (0x4000 → 0x8000).
  - AR/2 truncates toward zero (−3 → −1).
- Requester drops req before its ack: the operation completes, ack still pulses and result updates.
- A req still high in the IDLE cycle after its ack counts as a new request.

## Timing
- Reset values (async, immediate): state IDLE, ack 0, result 0, grant_id 0, busy 0, op_count 0, all strobes 0, Data_AR/BR 0, RR pointer 1.
- req sampled high at IDLE edge k: LOAD in cycle k+1, DECIDE k+2, EXEC k+3, ack/result in cycle k+4. Next grant is sampled at the IDLE edge k+5.
- Throughput: one operation per 5 cycles under continuous requests.
- Datapath acts on the negedge inside the strobe cycle. Flags are therefore valid at the DECIDE posedge, and CR is valid at the RESP posedge.
- Operands must be stable at the IDLE sampling edge only; later changes are ignored.
- Reset mid-operation: abort immediately to IDLE, with no ack for the aborted request. Requests still pending after release are re-arbitrated from pointer=1.

## Structure
- Package dp_share_pkg: state enum (IDLE, LOAD, DECIDE, EXEC, RESP), op enum (OP_MUL, OP_DIV, OP_CLR), WIDTH default.
- Sub-module rr_arb2: 2-way round-robin picker (req[1:0], pointer → grant valid + index), pointer updated on RESP.
- Top holds the FSM, op/operand registers, result and counter.

## Test plan
- Single request, req=01, AR=5, BR=7 → Mul strobe in EXEC; ack=01 four cycles after sampling; result=14; op_count=1.
- Negative AR: req=10, AR=−3 (0xFFFD) → Div strobe; ack=10; result=0xFFFF (−1); grant_id=1.
- Zero AR and overflow:
  - AR=0, BR=123 → Clr strobe, result=0.
  - AR=1, BR=0x4000 → result=0x8000.
- Contention, req=11 held for 4 ops → acks alternate 01, 10, 01, 10, each 5 cycles apart; no cycle has two strobes.
- Reset mid-op: assert reset_b=0 during EXEC → all outputs zero at once, no ack. After release with req=11 → requester 0 served first.
- Wrap: 256 consecutive ops → op_count returns to 0; early req drop → ack still pulses.
